// File: rtl/load_store_unit_if.sv
// Pipeline/memory bus bundle for load_store_unit.
// Latency: none (signal bundle only).
// Backpressure: stall is driven by the slave; the master holds its request while stall is high.
// Ports: req_valid/req_we/funct3/addr/wdata (request), stall/rdata/rdata_valid/misalign_err
// (response), mem_we/mem_a/mem_wd/mem_rd (word-addressed data memory, combinational read).
interface load_store_unit_if #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 32
);
    // Request from the MEM stage
    logic                     req_valid;
    logic                     req_we;
    logic [2:0]               funct3;
    logic [31:0]              addr;
    logic [DATA_WIDTH-1:0]    wdata;

    // Response to the pipeline
    logic                     stall;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     rdata_valid;
    logic                     misalign_err;

    // Data memory side
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0]    mem_wd;
    logic [DATA_WIDTH-1:0]    mem_rd;

    // Pipeline + memory environment
    modport master (
        output req_valid, req_we, funct3, addr, wdata, mem_rd,
        input  stall, rdata, rdata_valid, misalign_err, mem_we, mem_a, mem_wd
    );

    // Load/store unit
    modport slave (
        input  req_valid, req_we, funct3, addr, wdata, mem_rd,
        output stall, rdata, rdata_valid, misalign_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RV32 load/store to word-addressed memory, sub-word stores as same-cycle RMW.
// Latency: 0 cycles for aligned-within-word accesses; word-crossing accesses take 2 cycles.
// Backpressure: stall=1 during the first half of a split access; the request must be held.
// Ports: clk, rst_n (synchronous, active low), bus (load_store_unit_if.slave).
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses (misalign_err pulse)
// instead of splitting them; the split FSM path is then compiled out.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] nidx_q, nidx_d;
    logic [2:0]               funct3_q, funct3_d;
    logic                     we_q, we_d;
    logic [1:0]               off_q, off_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    lo_q, lo_d;

    logic [1:0]               off;
    logic [ADDRESS_WIDTH-1:0] widx;
    logic                     op_ok;
    logic                     in_second;
    logic [2:0]               cur_f3;
    logic [1:0]               cur_off;
    logic [DATA_WIDTH-1:0]    cur_wdata;
    logic [3:0]               lanes4;
    logic [7:0]               mask8;
    logic [2*DATA_WIDTH-1:0]  wide;
    logic [DATA_WIDTH-1:0]    rd_shift;
    logic [5:0]               sh_hi;
    logic                     unused_addr_hi;

    assign off            = bus.addr[1:0];
    assign widx           = bus.addr[ADDRESS_WIDTH+1:2];
    assign unused_addr_hi = ^bus.addr[31:ADDRESS_WIDTH+2];

    // Replace the byte lanes selected by be with the corresponding lanes of new_w.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            merge[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
    endfunction

    // funct3[2]=1 selects zero extension (LBU/LHU).
    function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   ext = {{24{d[7]  & ~f3[2]}}, d[7:0]};
            2'b01:   ext = {{16{d[15] & ~f3[2]}}, d[15:0]};
            default: ext = d;
        endcase
    endfunction

    always_comb begin
        if (bus.req_we) begin
            op_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
        end else begin
            op_ok = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b110) && (bus.funct3 != 3'b111);
        end
    end

    // In SECOND every lane computation runs from the latched request, so the live inputs
    // are free to change.
    assign in_second = (state_q == SECOND);
    assign cur_f3    = in_second ? funct3_q : bus.funct3;
    assign cur_off   = in_second ? off_q    : off;
    assign cur_wdata = in_second ? wdata_q  : bus.wdata;

    always_comb begin
        case (cur_f3[1:0])
            2'b00:   lanes4 = 4'b0001;
            2'b01:   lanes4 = 4'b0011;
            default: lanes4 = 4'b1111;
        endcase
    end

    // Two-word view of the access: low nibble/word hit widx, high nibble/word hit widx+1.
    assign mask8    = {4'b0000, lanes4} << cur_off;
    assign wide     = {{DATA_WIDTH{1'b0}}, cur_wdata} << {cur_off, 3'b000};
    assign rd_shift = bus.mem_rd >> {off, 3'b000};
    // Bytes already collected from the low word occupy 32-8*off bits.
    assign sh_hi    = 6'd32 - {1'b0, off_q, 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((bus.funct3[1:0] == 2'b01) && off[0]) ||
                        ((bus.funct3[1:0] == 2'b10) && (off != 2'b00));
`else
    logic split;
    assign split = |mask8[7:4];
`endif

    always_comb begin
        state_d          = state_q;
        nidx_d           = nidx_q;
        funct3_d         = funct3_q;
        we_d             = we_q;
        off_d            = off_q;
        wdata_d          = wdata_q;
        lo_d             = lo_q;
        bus.mem_a        = widx;
        bus.mem_we       = 1'b0;
        bus.mem_wd       = '0;
        bus.rdata        = '0;
        bus.rdata_valid  = 1'b0;
        bus.stall        = 1'b0;
        bus.misalign_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && op_ok) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        bus.misalign_err = 1'b1;
                    end else if (bus.req_we) begin
                        bus.mem_we = 1'b1;
                        bus.mem_wd = merge(bus.mem_rd, wide[31:0], mask8[3:0]);
                    end else begin
                        bus.rdata       = ext(rd_shift, bus.funct3);
                        bus.rdata_valid = 1'b1;
                    end
`else
                    // For a split store this is the low-word half: mask8[3:0] covers lanes off..3.
                    if (bus.req_we) begin
                        bus.mem_we = 1'b1;
                        bus.mem_wd = merge(bus.mem_rd, wide[31:0], mask8[3:0]);
                    end else if (!split) begin
                        bus.rdata       = ext(rd_shift, bus.funct3);
                        bus.rdata_valid = 1'b1;
                    end
                    if (split) begin
                        bus.stall = 1'b1;
                        state_d   = SECOND;
                        nidx_d    = widx + 1'b1;
                        funct3_d  = bus.funct3;
                        we_d      = bus.req_we;
                        off_d     = off;
                        wdata_d   = bus.wdata;
                        lo_d      = rd_shift;
                    end
`endif
                end
            end
            SECOND: begin
`ifdef LSU_MISALIGN_TRAP_EN
                state_d = IDLE;
`else
                bus.mem_a = nidx_q;
                if (we_q) begin
                    bus.mem_we = 1'b1;
                    bus.mem_wd = merge(bus.mem_rd, wide[63:32], mask8[7:4]);
                end else begin
                    bus.rdata       = ext(lo_q | (bus.mem_rd << sh_hi), funct3_q);
                    bus.rdata_valid = 1'b1;
                end
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Reset must block writes even in the middle of a split store.
        if (!rst_n) begin
            bus.mem_a        = '0;
            bus.mem_we       = 1'b0;
            bus.mem_wd       = '0;
            bus.rdata        = '0;
            bus.rdata_valid  = 1'b0;
            bus.stall        = 1'b0;
            bus.misalign_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            nidx_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            off_q    <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            nidx_q   <= nidx_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        pre_we;
    logic [16:0] pre_a;
    logic [31:0] pre_wd;
    logic [31:0] mem [0:131071];
    int          checks;
    int          errors;

    load_store_unit_if #(.ADDRESS_WIDTH(17), .DATA_WIDTH(32)) bus ();

    load_store_unit #(.ADDRESS_WIDTH(17), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rd = mem[bus.mem_a];

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_wd;
        else if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
    endtask

    task automatic preload(input logic [16:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = idx;
        pre_wd = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3'b010, 32'h14, 32'h12345678);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", bus.stall); end
        checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL rst_rdata_valid: got %b expected 0", bus.rdata_valid); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 00000000", bus.rdata); end
        checks++; if (bus.mem_a !== 17'h0) begin errors++; $display("FAIL rst_mem_a: got %h expected 0", bus.mem_a); end
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", bus.misalign_err); end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        preload(17'd5, 32'h8899AABB);
        drive(1'b1, 1'b0, 3'b000, 32'h15, 32'h0);   // LB
        #1;
        checks++; if (bus.rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_rdata: got %h expected FFFFFFAA", bus.rdata); end
        checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b expected 1", bus.rdata_valid); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lb_stall: got %b expected 0", bus.stall); end
        checks++; if (bus.mem_a !== 17'd5) begin errors++; $display("FAIL lb_mem_a: got %h expected 5", bus.mem_a); end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b100, 32'h15, 32'h0);   // LBU
        #1;
        checks++; if (bus.rdata !== 32'h000000AA) begin errors++; $display("FAIL lbu_rdata: got %h expected 000000AA", bus.rdata); end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b001, 32'h16, 32'h0);   // LH
        #1;
        checks++; if (bus.rdata !== 32'hFFFF8899) begin errors++; $display("FAIL lh_rdata: got %h expected FFFF8899", bus.rdata); end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b101, 32'h14, 32'h0);   // LHU
        #1;
        checks++; if (bus.rdata !== 32'h0000AABB) begin errors++; $display("FAIL lhu_rdata: got %h expected 0000AABB", bus.rdata); end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);   // LW
        #1;
        checks++; if (bus.rdata !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata: got %h expected 8899AABB", bus.rdata); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_store;
        preload(17'd5, 32'h11223344);
        drive(1'b1, 1'b1, 3'b001, 32'h16, 32'hDEADBEEF);   // SH
        #1;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sh_mem_we: got %b expected 1", bus.mem_we); end
        checks++; if (bus.mem_wd !== 32'hBEEF3344) begin errors++; $display("FAIL sh_mem_wd: got %h expected BEEF3344", bus.mem_wd); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sh_stall: got %b expected 0", bus.stall); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL sh_we_pulse: got %b expected 0", bus.mem_we); end
        checks++; if (mem[5] !== 32'hBEEF3344) begin errors++; $display("FAIL sh_word5: got %h expected BEEF3344", mem[5]); end
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b000, 32'h17, 32'h00000055);   // SB lane 3
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (mem[5] !== 32'h55EF3344) begin errors++; $display("FAIL sb_word5: got %h expected 55EF3344", mem[5]); end
    endtask

    task automatic test_noop;
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b011, 32'h14, 32'h0);
        #1;
        checks++; if (bus.rdata_valid !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL noop_load: got valid=%b rdata=%h expected 0/0", bus.rdata_valid, bus.rdata); end
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b100, 32'h14, 32'hFFFFFFFF);
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL noop_store: got we=%b stall=%b expected 0/0", bus.mem_we, bus.stall); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (mem[5] !== 32'h55EF3344) begin errors++; $display("FAIL noop_word5: got %h expected 55EF3344", mem[5]); end
    endtask

`ifndef LSU_MISALIGN_TRAP_EN
    task automatic test_split_load;
        preload(17'd2, 32'h44332211);
        preload(17'd3, 32'h88776655);
        drive(1'b1, 1'b0, 3'b010, 32'h0A, 32'h0);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL slw_stall1: got %b expected 1", bus.stall); end
        checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL slw_valid1: got %b expected 0", bus.rdata_valid); end
        checks++; if (bus.mem_a !== 17'd2) begin errors++; $display("FAIL slw_mem_a1: got %h expected 2", bus.mem_a); end
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b010, 32'h40, 32'hFFFFFFFF);   // ignored in SECOND
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL slw_stall2: got %b expected 0", bus.stall); end
        checks++; if (bus.mem_a !== 17'd3) begin errors++; $display("FAIL slw_mem_a2: got %h expected 3", bus.mem_a); end
        checks++; if (bus.rdata !== 32'h66554433) begin errors++; $display("FAIL slw_rdata: got %h expected 66554433", bus.rdata); end
        checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL slw_valid2: got %b expected 1", bus.rdata_valid); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL slw_mem_we: got %b expected 0", bus.mem_we); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_split_store;
        preload(17'd1, 32'hCAFEF00D);
        preload(17'd2, 32'h0);
        preload(17'd3, 32'h0);
        preload(17'd4, 32'h5EED5EED);
        drive(1'b1, 1'b1, 3'b010, 32'h0B, 32'hA1B2C3D4);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ssw_stall1: got %b expected 1", bus.stall); end
        checks++; if (bus.mem_wd !== 32'hD4000000) begin errors++; $display("FAIL ssw_wd1: got %h expected D4000000", bus.mem_wd); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_a !== 17'd3) begin errors++; $display("FAIL ssw_second: got we=%b a=%h expected 1/3", bus.mem_we, bus.mem_a); end
        @(negedge clk);
        checks++; if (mem[2] !== 32'hD4000000) begin errors++; $display("FAIL ssw_word2: got %h expected D4000000", mem[2]); end
        checks++; if (mem[3] !== 32'h00A1B2C3) begin errors++; $display("FAIL ssw_word3: got %h expected 00A1B2C3", mem[3]); end
        checks++; if (mem[1] !== 32'hCAFEF00D || mem[4] !== 32'h5EED5EED) begin errors++; $display("FAIL ssw_neighbours: got %h %h expected CAFEF00D 5EED5EED", mem[1], mem[4]); end
    endtask

    task automatic test_reset_mid_split;
        preload(17'd0, 32'h0BADBEEF);
        preload(17'd2, 32'h0);
        preload(17'd3, 32'h12345678);
        drive(1'b1, 1'b1, 3'b010, 32'h0B, 32'hA1B2C3D4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL rmid_outputs: got we=%b stall=%b expected 0/0", bus.mem_we, bus.stall); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        checks++; if (mem[3] !== 32'h12345678) begin errors++; $display("FAIL rmid_word3: got %h expected 12345678", mem[3]); end
        checks++; if (mem[2] !== 32'hD4000000) begin errors++; $display("FAIL rmid_word2: got %h expected D4000000", mem[2]); end
        checks++; if (bus.stall !== 1'b0 || bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL rmid_next_lw: got stall=%b valid=%b expected 0/1", bus.stall, bus.rdata_valid); end
        checks++; if (bus.rdata !== 32'h0BADBEEF) begin errors++; $display("FAIL rmid_next_rdata: got %h expected 0BADBEEF", bus.rdata); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_wrap;
        preload(17'h1FFFF, 32'hAB000000);
        drive(1'b1, 1'b0, 3'b001, 32'h001FFFFF, 32'h0);   // LH, widx=2**17-1, off=3
        #1;
        checks++; if (bus.mem_a !== 17'h1FFFF || bus.stall !== 1'b1) begin errors++; $display("FAIL wrap_first: got a=%h stall=%b expected 1FFFF/1", bus.mem_a, bus.stall); end
        @(negedge clk);
        #1;
        checks++; if (bus.mem_a !== 17'h0) begin errors++; $display("FAIL wrap_mem_a: got %h expected 0", bus.mem_a); end
        checks++; if (bus.rdata !== 32'hFFFFEFAB) begin errors++; $display("FAIL wrap_rdata: got %h expected FFFFEFAB", bus.rdata); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask
`else
    task automatic test_misalign;
        preload(17'd2, 32'h0);
        preload(17'd3, 32'h0);
        drive(1'b1, 1'b1, 3'b010, 32'h0B, 32'hA1B2C3D4);
        #1;
        checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", bus.misalign_err); end
        checks++; if (bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL mis_we_stall: got we=%b stall=%b expected 0/0", bus.mem_we, bus.stall); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", bus.misalign_err); end
        checks++; if (mem[2] !== 32'h0 || mem[3] !== 32'h0) begin errors++; $display("FAIL mis_words: got %h %h expected 0 0", mem[2], mem[3]); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        pre_we = 1'b0;
        pre_a  = '0;
        pre_wd = '0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        test_reset;
        test_load;
        test_store;
        test_noop;
`ifndef LSU_MISALIGN_TRAP_EN
        test_split_load;
        test_split_store;
        test_reset_mid_split;
        test_wrap;
`else
        test_misalign;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
